alu_control_unit: RTL and testbench
===================================

ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

Interface
- REQ-001: The block SHALL have one clock and a synchronous, active-high reset.
- REQ-002: clk  input  1  rising-edge clock; all state updates on its rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: in_valid  input  1  ALUopt/func qualify this cycle.
- REQ-005: ALUopt  input  3  main-decoder ALU operation class.
- REQ-006: func  input  6  R-type funct field (instr[5:0]).
- REQ-007: ALUctr  output  3  registered ALU operation select.
- REQ-008: out_valid  output  1  ALUctr/illegal updated from a valid request last cycle.
- REQ-009: illegal  output  1  last valid request had an undecodable ALUopt/func pair.

Function
- REQ-010: ALUctr encoding SHALL be: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT; 101 unused, never driven.
- REQ-011: ALUopt 000 (load/store/addi) SHALL yield ADD, func ignored.
- REQ-012: ALUopt 001 (beq/bne) SHALL yield SUB, func ignored.
- REQ-013: ALUopt 010 (ori) SHALL yield OR, func ignored.
- REQ-014: ALUopt 011 (andi) SHALL yield AND, func ignored.
- REQ-015: ALUopt 101 (slti) SHALL yield SLT, func ignored.
- REQ-016: ALUopt 100 (R-type) SHALL decode func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
- REQ-017: ALUopt 110 and 111 SHALL be illegal.
- REQ-018: Any ALUopt 100 func not decoded per REQ-016 (or REQ-027 when enabled) SHALL be illegal.
- REQ-019: An illegal request SHALL register ALUctr=010 (ADD) and illegal=1; a legal one SHALL register illegal=0.
- REQ-020: Latency SHALL be exactly one cycle: request with in_valid=1 at edge N appears on ALUctr/illegal with out_valid=1 after edge N.
- REQ-021: Cycles with in_valid=0 SHALL hold ALUctr and illegal at their previous values and drive out_valid=0 after the edge.
- REQ-022: Back-to-back valid requests SHALL each produce a result on consecutive cycles; no stall, no backpressure.
- REQ-023: Inputs SHALL be sampled only at the clock edge; combinational glitches on ALUopt/func SHALL NOT reach outputs.

Reset
- REQ-024: While rst=1 at a rising edge, ALUctr SHALL become 000, out_valid 0, illegal 0, regardless of in_valid.
- REQ-025: A request presented in the same cycle as rst=1 SHALL be discarded; normal decode resumes at the first edge with rst=0.

Configuration
- REQ-026: Macro ALU_CTRL_EXT_FUNC_EN SHALL select extended R-type decode.
- REQ-027: With ALU_CTRL_EXT_FUNC_EN defined, ALUopt 100 SHALL also decode: func 100001 (addu) ADD, 100011 (subu) SUB, 100110 (xor) XOR, 100111 (nor) NOR.
- REQ-028: Without the macro, those four func codes SHALL be illegal per REQ-019, and ALUctr 011/100 SHALL never be driven.

Verification
- REQ-029: rst=1 one cycle with in_valid=1, ALUopt=100, func=100010 -> ALUctr=000, out_valid=0, illegal=0.
- REQ-030: Valid ALUopt=100 with func 100000/100010/100101/100100/101010 on consecutive cycles -> ALUctr 010/110/001/000/111 one cycle later each, out_valid=1, illegal=0.
- REQ-031: Valid ALUopt 000/001/010 with func=000000 -> ALUctr 010/110/001, illegal=0.
- REQ-032: Valid ALUopt=100, func=000000, then ALUopt=111 -> ALUctr=010, illegal=1 both cycles.
- REQ-033: Valid ALUopt=001, then in_valid=0 with ALUopt=000 for 3 cycles -> ALUctr stays 110, out_valid=0, illegal=0.
- REQ-034: Valid ALUopt=100, func=100110 -> ALUctr=011, illegal=0 with ALU_CTRL_EXT_FUNC_EN; ALUctr=010, illegal=1 without.

Source files
------------

// File: rtl/alu_control_unit_if.sv
// -----------------------------------------------------------------------------
// alu_control_unit_if
// Request/result bundle for the ALU control decoder.
//   in_valid  : request qualifier, ALUopt/func meaningful this cycle
//   ALUopt    : main-decoder ALU operation class (3 bits)
//   func      : R-type funct field, instr[5:0] (6 bits)
//   ALUctr    : registered ALU operation select (3 bits)
//   out_valid : ALUctr/illegal were updated from a valid request last cycle
//   illegal   : last valid request had an undecodable ALUopt/func pair
// Modports:
//   master : issues requests, observes results
//   slave  : the decoder itself
// -----------------------------------------------------------------------------
interface alu_control_unit_if;
  logic       in_valid;
  logic [2:0] ALUopt;
  logic [5:0] func;
  logic [2:0] ALUctr;
  logic       out_valid;
  logic       illegal;

  modport master (
    output in_valid, ALUopt, func,
    input  ALUctr, out_valid, illegal
  );

  modport slave (
    input  in_valid, ALUopt, func,
    output ALUctr, out_valid, illegal
  );
endinterface

// File: rtl/alu_control_unit.sv
// -----------------------------------------------------------------------------
// alu_control_unit
// Translates the main decoder's ALU operation class plus the R-type funct
// field into a 3-bit ALU operation select. One-cycle latency, no stall.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_control_unit_if.slave (in_valid/ALUopt/func in,
//          ALUctr/out_valid/illegal out)
//
// ALUctr encoding: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB,
// 111 SLT; 101 is never produced.
//
// Configuration macro:
//   ALU_CTRL_EXT_FUNC_EN : when defined, R-type also decodes addu/subu/xor/nor.
//                          When undefined those funct codes are illegal and
//                          XOR/NOR selects are never produced.
// -----------------------------------------------------------------------------
module alu_control_unit (
  input logic              clk,
  input logic              rst,
  alu_control_unit_if.slave bus
);

  localparam logic [2:0] CTR_AND = 3'b000;
  localparam logic [2:0] CTR_OR  = 3'b001;
  localparam logic [2:0] CTR_ADD = 3'b010;
`ifdef ALU_CTRL_EXT_FUNC_EN
  localparam logic [2:0] CTR_XOR = 3'b011;
  localparam logic [2:0] CTR_NOR = 3'b100;
`endif
  localparam logic [2:0] CTR_SUB = 3'b110;
  localparam logic [2:0] CTR_SLT = 3'b111;

  logic [2:0] ctr_reg;
  logic [2:0] ctr_next;
  logic       illegal_reg;
  logic       illegal_next;
  logic       valid_reg;

  // Pure decode of the current inputs. Undecodable pairs fall back to ADD so
  // a downstream ALU always sees a benign operation alongside illegal=1.
  always_comb begin
    ctr_next     = CTR_ADD;
    illegal_next = 1'b0;
    case (bus.ALUopt)
      3'b000: ctr_next = CTR_ADD;   // load/store/addi
      3'b001: ctr_next = CTR_SUB;   // beq/bne
      3'b010: ctr_next = CTR_OR;    // ori
      3'b011: ctr_next = CTR_AND;   // andi
      3'b101: ctr_next = CTR_SLT;   // slti
      3'b100: begin                 // R-type, decode funct
        case (bus.func)
          6'b100000: ctr_next = CTR_ADD;
          6'b100010: ctr_next = CTR_SUB;
          6'b100100: ctr_next = CTR_AND;
          6'b100101: ctr_next = CTR_OR;
          6'b101010: ctr_next = CTR_SLT;
`ifdef ALU_CTRL_EXT_FUNC_EN
          6'b100001: ctr_next = CTR_ADD;  // addu
          6'b100011: ctr_next = CTR_SUB;  // subu
          6'b100110: ctr_next = CTR_XOR;
          6'b100111: ctr_next = CTR_NOR;
`endif
          default: begin
            ctr_next     = CTR_ADD;
            illegal_next = 1'b1;
          end
        endcase
      end
      default: begin                // 110, 111
        ctr_next     = CTR_ADD;
        illegal_next = 1'b1;
      end
    endcase
  end

  // Result registers only load on a valid request; idle cycles keep the last
  // result visible but drop out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_reg     <= CTR_AND;
      illegal_reg <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        ctr_reg     <= ctr_next;
        illegal_reg <= illegal_next;
      end
    end
  end

  assign bus.ALUctr    = ctr_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.out_valid = valid_reg;

endmodule

// File: tb/tb_alu_control_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_control_unit
// Self-checking bench: directed vectors from the requirement list followed by
// randomized traffic, compared each cycle against a table-driven reference.
// Define ALU_CTRL_EXT_FUNC_EN for both bench and RTL to cover extended decode.
// -----------------------------------------------------------------------------
module tb_alu_control_unit;

  logic clk = 1'b0;
  logic rst;

  alu_control_unit_if bus ();

  alu_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef ALU_CTRL_EXT_FUNC_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  // R-type funct table: code, resulting select, and whether it needs EXT.
  logic [5:0] r_func [0:8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b101010, 6'b100001, 6'b100011, 6'b100110,
                              6'b100111};
  logic [2:0] r_ctr  [0:8] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd7,
                              3'd2, 3'd6, 3'd3, 3'd4};
  bit         r_ext  [0:8] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
  // Non-R-type classes indexed by ALUopt (entry 4 unused, 6/7 illegal).
  logic [2:0] op_ctr [0:5] = '{3'd2, 3'd6, 3'd1, 3'd0, 3'd0, 3'd7};

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state of the registered outputs.
  logic [2:0] m_ctr;
  logic       m_ill;
  logic       m_val;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(input logic [2:0] opt, input logic [5:0] f,
                                     output logic [2:0] c, output logic ill);
    c   = 3'd2;
    ill = 1'b1;
    if (opt == 3'd4) begin
      for (int i = 0; i < 9; i++)
        if (r_func[i] == f && (!r_ext[i] || EXT)) begin
          c   = r_ctr[i];
          ill = 1'b0;
        end
    end else if (opt <= 3'd5) begin
      c   = op_ctr[opt];
      ill = 1'b0;
    end
  endfunction

  // Apply one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input logic r, input logic v, input logic [2:0] opt,
                      input logic [5:0] f, input string tag);
    logic [2:0] c;
    logic       il;
    rst          = r;
    bus.in_valid = v;
    bus.ALUopt   = opt;
    bus.func     = f;
    @(posedge clk);
    if (r) begin
      m_ctr = 3'd0; m_ill = 1'b0; m_val = 1'b0;
    end else begin
      m_val = v;
      if (v) begin
        ref_decode(opt, f, c, il);
        m_ctr = c; m_ill = il;
      end
    end
    #1;
    $display("%s rst=%0b v=%0b opt=%03b func=%06b -> ctr=%03b ov=%0b ill=%0b",
             tag, r, v, opt, f, bus.ALUctr, bus.out_valid, bus.illegal);
    check({tag, ".ctr"},   {5'd0, bus.ALUctr},   {5'd0, m_ctr});
    check({tag, ".valid"}, {7'd0, bus.out_valid}, {7'd0, m_val});
    check({tag, ".ill"},   {7'd0, bus.illegal},   {7'd0, m_ill});
  endtask

  // Absolute expectation straight from the requirement text.
  task automatic expect_out(input string tag, input logic [2:0] c,
                            input logic ov, input logic il);
    check({tag, ".ctr_abs"},   {5'd0, bus.ALUctr},    {5'd0, c});
    check({tag, ".valid_abs"}, {7'd0, bus.out_valid}, {7'd0, ov});
    check({tag, ".ill_abs"},   {7'd0, bus.illegal},   {7'd0, il});
  endtask

  initial begin
    logic [2:0] opt;
    logic [5:0] f;
    int         k;

    step(1'b1, 1'b0, 3'd0, 6'd0, "reset0");
    step(1'b1, 1'b1, 3'b100, 6'b100010, "reset_req");
    expect_out("reset_req", 3'b000, 1'b0, 1'b0);

    // Consecutive R-type decodes.
    step(1'b0, 1'b1, 3'b100, 6'b100000, "r_add"); expect_out("r_add", 3'b010, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'b100, 6'b100010, "r_sub"); expect_out("r_sub", 3'b110, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'b100, 6'b100101, "r_or");  expect_out("r_or",  3'b001, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'b100, 6'b100100, "r_and"); expect_out("r_and", 3'b000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'b100, 6'b101010, "r_slt"); expect_out("r_slt", 3'b111, 1'b1, 1'b0);

    // Immediate classes with func ignored.
    step(1'b0, 1'b1, 3'b000, 6'd0, "op_ld");  expect_out("op_ld",  3'b010, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'b001, 6'd0, "op_br");  expect_out("op_br",  3'b110, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3'b010, 6'd0, "op_ori"); expect_out("op_ori", 3'b001, 1'b1, 1'b0);

    // Illegal requests.
    step(1'b0, 1'b1, 3'b100, 6'b000000, "ill_func"); expect_out("ill_func", 3'b010, 1'b1, 1'b1);
    step(1'b0, 1'b1, 3'b111, 6'b000000, "ill_op");   expect_out("ill_op",   3'b010, 1'b1, 1'b1);

    // Hold across idle cycles.
    step(1'b0, 1'b1, 3'b001, 6'd0, "hold_set");
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 3'b000, 6'd0, "hold");
      expect_out("hold", 3'b110, 1'b0, 1'b0);
    end

    // Extended funct code.
    step(1'b0, 1'b1, 3'b100, 6'b100110, "r_xor");
    if (EXT) expect_out("r_xor", 3'b011, 1'b1, 1'b0);
    else     expect_out("r_xor", 3'b010, 1'b1, 1'b1);

    // Randomized traffic, biased toward meaningful funct codes.
    for (int i = 0; i < 400; i++) begin
      opt = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 8);
        f = r_func[k];
      end else begin
        f = 6'($urandom);
      end
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), opt, f, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
